// File: rtl/sdi_source_scheduler_pkg.sv
// Shared constants for the HD-SDI source scheduler: FSM encoding, blanking levels
// and the 75% BT.709 10-bit colour-bar table.
package sdi_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_STOP = 2'd3;

   localparam logic [9:0] BLANK_Y = 10'h040;
   localparam logic [9:0] BLANK_C = 10'h200;

   typedef struct packed {
      logic [9:0] y;
      logic [9:0] cb;
      logic [9:0] cr;
   } bar_t;

   function automatic bar_t bar_lookup(input logic [2:0] idx);
      bar_t b;
      case (idx)
         3'd0:    b = '{y: 10'd721, cb: 10'd512, cr: 10'd512};
         3'd1:    b = '{y: 10'd674, cb: 10'd176, cr: 10'd543};
         3'd2:    b = '{y: 10'd581, cb: 10'd589, cr: 10'd176};
         3'd3:    b = '{y: 10'd534, cb: 10'd253, cr: 10'd207};
         3'd4:    b = '{y: 10'd251, cb: 10'd771, cr: 10'd817};
         3'd5:    b = '{y: 10'd204, cb: 10'd435, cr: 10'd848};
         3'd6:    b = '{y: 10'd111, cb: 10'd848, cr: 10'd481};
         default: b = '{y: 10'd64,  cb: 10'd512, cr: 10'd512};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sdi_source_scheduler_colorbar.sv
// 8-bar pattern source: pixel counter restarted by each active run, plus table lookup.
module sdi_colorbar_gen
   import sdi_pkg::*;
#(
   parameter int H_ACTIVE  = 1920,
   parameter int BAR_WIDTH = 240
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       i_DATA_RQ,
   output logic [9:0] Y_o,
   output logic [9:0] C_o
);

   localparam int X_W = $clog2(H_ACTIVE + 1);
   localparam logic [X_W-1:0] X_ONE = X_W'(1);

   logic [X_W-1:0] x_q, x_d;
   logic [2:0]     idx;
   int             idx_int;
   bar_t           bar;

   always_comb begin
      x_d     = i_DATA_RQ ? x_q + X_ONE : '0;
      idx_int = int'(x_q) / BAR_WIDTH;
      idx     = (idx_int > 7) ? 3'd7 : 3'(idx_int);
      bar     = bar_lookup(idx);
      Y_o     = bar.y;
      // 4:2:2 interleave: even pixels carry Cb, odd pixels Cr
      C_o     = x_q[0] ? bar.cr : bar.cb;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) x_q <= '0;
      else       x_q <= x_d;
   end

endmodule

// File: rtl/sdi_source_scheduler.sv
// Drives the 1080p30 SDI generator: run/stop FSM, per-frame live/bars source choice,
// underflow black-fill and forced fallback to bars after repeated underflow.
module sdi_source_scheduler
   import sdi_pkg::*;
#(
   parameter int H_ACTIVE    = 1920,
   parameter int BAR_WIDTH   = 240,
   parameter int UF_LIMIT    = 3,
   parameter int ARM_TIMEOUT = 2500000
) (
   input  logic       i_CLK_74m25,
   input  logic       i_RST,
   input  logic       i_START,
   input  logic       i_SRC_SEL,
   input  logic       i_CLR,
   input  logic       i_DATA_RQ,
   input  logic       i_VSYNC,
   input  logic       i_fifo_empty,
   input  logic [9:0] i_fifo_Y,
   input  logic [9:0] i_fifo_C,
   output logic       o_fifo_rd,
   output logic       GEN_EN_o,
   output logic [9:0] Y_o,
   output logic [9:0] C_o,
   output logic       SRC_ACTIVE_o,
   output logic       UNDERFLOW_o,
   output logic       ERR_o,
   output logic [1:0] STATE_o
);

   localparam logic [21:0] ARM_LAST = 22'(ARM_TIMEOUT - 1);
   localparam logic [1:0]  UF_LIM   = 2'(UF_LIMIT);

   logic [1:0]  state_q, state_d;
   logic [21:0] arm_cnt_q, arm_cnt_d;
   logic [1:0]  uf_cnt_q, uf_cnt_d, uf_next;
   logic        vsync_q;
   logic        src_q, src_d, force_q, force_d, fuf_q, fuf_d;
   logic        ufl_q, ufl_d, err_q, err_d;
   logic        frame_start, frame_end, live, uf_now;
   logic [9:0]  bar_y, bar_c;

   sdi_colorbar_gen #(.H_ACTIVE(H_ACTIVE), .BAR_WIDTH(BAR_WIDTH)) u_bars (
      .clk_i     (i_CLK_74m25),
      .rst_i     (i_RST),
      .i_DATA_RQ (i_DATA_RQ),
      .Y_o       (bar_y),
      .C_o       (bar_c)
   );

   assign frame_start = vsync_q & ~i_VSYNC;
   assign frame_end   = ~vsync_q & i_VSYNC;
   // live data only flows while the generator is actually running a frame
   assign live        = src_q & (state_q == ST_RUN || state_q == ST_STOP);
   assign uf_now      = i_DATA_RQ & live & i_fifo_empty;

   assign o_fifo_rd    = i_DATA_RQ & live & ~i_fifo_empty;
   assign GEN_EN_o     = (state_q != ST_IDLE);
   assign SRC_ACTIVE_o = src_q;
   assign UNDERFLOW_o  = ufl_q;
   assign ERR_o        = err_q;
   assign STATE_o      = state_q;

   always_comb begin
      Y_o = BLANK_Y;
      C_o = BLANK_C;
      if (i_DATA_RQ && state_q != ST_IDLE) begin
         if (live) begin
            if (!i_fifo_empty) begin
               Y_o = i_fifo_Y;
               C_o = i_fifo_C;
            end
         end else begin
            Y_o = bar_y;
            C_o = bar_c;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      err_d     = err_q & ~i_CLR;
      ufl_d     = (ufl_q & ~i_CLR) | uf_now;
      force_d   = force_q & ~i_CLR;
      uf_cnt_d  = i_CLR ? 2'd0 : uf_cnt_q;
      uf_next   = uf_cnt_q;
      src_d     = frame_start ? (i_SRC_SEL & ~force_q) : src_q;
      fuf_d     = (frame_start ? 1'b0 : fuf_q) | uf_now;

      case (state_q)
         ST_IDLE: if (i_START) begin
            state_d   = ST_ARM;
            arm_cnt_d = '0;
         end
         ST_ARM: begin
            arm_cnt_d = arm_cnt_q + 22'd1;
            if (!i_START)                  state_d = ST_IDLE;
            else if (frame_start)          state_d = ST_RUN;
            else if (arm_cnt_q == ARM_LAST) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_RUN:  if (!i_START) state_d = ST_STOP;
         default: begin
            if (frame_end)    state_d = ST_IDLE;
            else if (i_START) state_d = ST_RUN;
         end
      endcase

      // a frame-end verdict overrides a same-cycle clear
      if (frame_end && live) begin
         if (fuf_q) uf_next = (uf_cnt_q == 2'd3) ? 2'd3 : uf_cnt_q + 2'd1;
         else       uf_next = 2'd0;
         uf_cnt_d = uf_next;
         if (uf_next >= UF_LIM) force_d = 1'b1;
      end
   end

   always_ff @(posedge i_CLK_74m25 or posedge i_RST) begin
      if (i_RST) begin
         state_q   <= ST_IDLE;
         arm_cnt_q <= '0;
         uf_cnt_q  <= '0;
         vsync_q   <= 1'b0;
         src_q     <= 1'b0;
         force_q   <= 1'b0;
         fuf_q     <= 1'b0;
         ufl_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         uf_cnt_q  <= uf_cnt_d;
         vsync_q   <= i_VSYNC;
         src_q     <= src_d;
         force_q   <= force_d;
         fuf_q     <= fuf_d;
         ufl_q     <= ufl_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_sdi_source_scheduler.sv
// Bench for sdi_source_scheduler: cycle-level reference model plus bar-table vectors,
// directed sequences for the multi-cycle corner cases and a randomized run.
module tb_sdi_source_scheduler;

   localparam int ARM_TO = 40;

   logic       clk = 1'b0;
   logic       rst, start, sel, clr, dreq, vs, empty;
   logic [9:0] fy, fc;
   logic       rd, gen_en, src_act, ufl, err;
   logic [9:0] y, c;
   logic [1:0] st;

   always #5 clk = ~clk;

   sdi_source_scheduler #(.ARM_TIMEOUT(ARM_TO)) dut (
      .i_CLK_74m25  (clk),
      .i_RST        (rst),
      .i_START      (start),
      .i_SRC_SEL    (sel),
      .i_CLR        (clr),
      .i_DATA_RQ    (dreq),
      .i_VSYNC      (vs),
      .i_fifo_empty (empty),
      .i_fifo_Y     (fy),
      .i_fifo_C     (fc),
      .o_fifo_rd    (rd),
      .GEN_EN_o     (gen_en),
      .Y_o          (y),
      .C_o          (c),
      .SRC_ACTIVE_o (src_act),
      .UNDERFLOW_o  (ufl),
      .ERR_o        (err),
      .STATE_o      (st)
   );

   int bar_yv [8] = '{721, 674, 581, 534, 251, 204, 111, 64};
   int bar_cb [8] = '{512, 176, 589, 253, 771, 435, 848, 512};
   int bar_cr [8] = '{512, 543, 176, 207, 817, 848, 481, 512};

   typedef struct { int x; int ey; int ec; } bar_vec_t;
   bar_vec_t bar_tab [8];

   int vectors = 0, miscompares = 0, pops = 0;
   bit tab_chk = 0, chaos = 0;

   // reference model state: spec-level quantities kept as plain integers
   int m_state, m_arm, m_ufc, m_px;
   bit m_pvs, m_src, m_force, m_fuf, m_ufl, m_err;

   task automatic model_reset();
      m_state = 0; m_arm = 0; m_ufc = 0; m_px = 0;
      m_pvs = 0; m_src = 0; m_force = 0; m_fuf = 0; m_ufl = 0; m_err = 0;
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", nm, got, exp);
      end
   endtask

   // one clock: compare outputs against the model mid-cycle, then advance the model
   task automatic tick();
      int ey, ec, erd, idx, n_state, n_ufc;
      bit live, fs, fe, ufn, n_err, n_ufl, n_force, n_src, n_fuf;
      #2;
      live = m_src && (m_state >= 2);
      ey = 64; ec = 512; erd = 0;
      if (dreq && m_state != 0) begin
         if (live) begin
            if (!empty) begin ey = fy; ec = fc; erd = 1; end
         end else begin
            idx = m_px / 240;
            if (idx > 7) idx = 7;
            ey = bar_yv[idx];
            ec = (m_px % 2 == 1) ? bar_cr[idx] : bar_cb[idx];
         end
      end
      vectors++;
      if (y !== 10'(ey) || c !== 10'(ec) || rd !== erd[0] || gen_en !== (m_state != 0) ||
          st !== 2'(m_state) || src_act !== m_src || ufl !== m_ufl || err !== m_err) begin
         miscompares++;
         $display("FAIL cycle @%0t: got st=%0d en=%b src=%b uf=%b err=%b rd=%b Y=%0d C=%0d; want st=%0d en=%b src=%b uf=%b err=%b rd=%0d Y=%0d C=%0d",
                  $time, st, gen_en, src_act, ufl, err, rd, y, c,
                  m_state, (m_state != 0), m_src, m_ufl, m_err, erd, ey, ec);
      end
      if (tab_chk && dreq)
         foreach (bar_tab[i])
            if (bar_tab[i].x == m_px) begin
               vectors++;
               if (y !== 10'(bar_tab[i].ey) || c !== 10'(bar_tab[i].ec)) begin
                  miscompares++;
                  $display("FAIL bar px %0d: got Y=%0d C=%0d, want Y=%0d C=%0d",
                           m_px, y, c, bar_tab[i].ey, bar_tab[i].ec);
               end
            end
      if (rd) pops++;

      fs  = m_pvs && !vs;
      fe  = !m_pvs && vs;
      ufn = dreq && live && empty;
      n_state = m_state;
      n_err   = m_err && !clr;
      n_ufl   = (m_ufl && !clr) || ufn;
      n_force = m_force && !clr;
      n_ufc   = clr ? 0 : m_ufc;
      case (m_state)
         0: if (start) begin n_state = 1; m_arm = 0; end
         1: begin
            if (!start) n_state = 0;
            else if (fs) n_state = 2;
            else if (m_arm == ARM_TO - 1) begin n_state = 0; n_err = 1; end
            m_arm++;
         end
         2: if (!start) n_state = 3;
         default: if (fe) n_state = 0; else if (start) n_state = 2;
      endcase
      if (fe && live) begin
         n_ufc = m_fuf ? ((m_ufc < 3) ? m_ufc + 1 : 3) : 0;
         if (n_ufc >= 3) n_force = 1;
      end
      n_src = fs ? (sel && !m_force) : m_src;
      n_fuf = (fs ? 1'b0 : m_fuf) || ufn;

      @(posedge clk);
      if (rst) model_reset();
      else begin
         m_state = n_state; m_err = n_err; m_ufl = n_ufl; m_force = n_force;
         m_ufc = n_ufc; m_src = n_src; m_fuf = n_fuf;
         m_px  = dreq ? m_px + 1 : 0;
         m_pvs = vs;
      end
      if (erd == 1) begin fy = 10'($urandom); fc = 10'($urandom); end
      #1;
   endtask

   task automatic step();
      if (chaos) begin
         if ($urandom_range(299) == 0) start = ~start;
         if ($urandom_range(99) == 0)  sel   = ~sel;
         clr = ($urandom_range(199) == 0);
      end
      tick();
   endtask

   task automatic do_frame(input int nlines, input int plen, input int vbl,
                           input int uf_line, input int uf_lo, input int uf_hi, input int uf_rate);
      vs = 1; dreq = 0; empty = 0;
      repeat (vbl) step();
      vs = 0;
      for (int l = 0; l < nlines; l++) begin
         dreq = 0; empty = 0;
         repeat (4) step();
         for (int p = 0; p < plen; p++) begin
            dreq  = 1;
            empty = (l == uf_line && p >= uf_lo && p <= uf_hi) ||
                    (uf_rate > 0 && $urandom_range(uf_rate - 1) == 0);
            step();
         end
      end
      dreq = 0; empty = 0;
      step();
   endtask

   task automatic pulse_clr();
      clr = 1; tick(); clr = 0;
   endtask

   initial begin
      int cnt;
      bar_tab[0] = '{0, 721, 512};    bar_tab[1] = '{1, 721, 512};
      bar_tab[2] = '{240, 674, 176};  bar_tab[3] = '{241, 674, 543};
      bar_tab[4] = '{480, 581, 589};  bar_tab[5] = '{1439, 204, 848};
      bar_tab[6] = '{1680, 64, 512};  bar_tab[7] = '{1919, 64, 512};

      rst = 1; start = 0; sel = 0; clr = 0; dreq = 0; vs = 1; empty = 0;
      fy = 10'($urandom); fc = 10'($urandom);
      model_reset();
      @(posedge clk); #1;
      tick(); tick();
      rst = 0;
      tick();

      // bars: enable follows start by one clock, RUN at first frame start
      tab_chk = 1; start = 1; sel = 0;
      tick();
      chk("gen_en after start", gen_en, 1);
      chk("state ARM", st, 1);
      do_frame(1, 1920, 10, -1, 0, 0, 0);
      chk("state RUN after frame", st, 2);
      tab_chk = 0;

      // live, FIFO never empty: one pop per active pixel
      sel = 1; pops = 0;
      do_frame(1, 1920, 10, -1, 0, 0, 0);
      chk("live pops per line", pops, 1920);
      chk("src live", src_act, 1);
      chk("no underflow", ufl, 0);

      // underflow on pixels 100..103, three frames running -> forced bars
      do_frame(3, 128, 8, 2, 100, 103, 0);
      chk("underflow sticky", ufl, 1);
      do_frame(3, 128, 8, 2, 100, 103, 0);
      do_frame(3, 128, 8, 2, 100, 103, 0);
      do_frame(2, 64, 8, -1, 0, 0, 0);
      chk("forced bars", src_act, 0);
      pulse_clr();
      chk("underflow cleared", ufl, 0);
      do_frame(2, 64, 8, -1, 0, 0, 0);
      chk("live restored", src_act, 1);

      // mid-frame source change waits for the next frame start
      vs = 1; repeat (8) tick();
      vs = 0; repeat (20) tick();
      sel = 0; repeat (20) tick();
      chk("src held mid-frame", src_act, 1);
      vs = 1; repeat (5) tick();
      chk("src held in blanking", src_act, 1);
      vs = 0; tick();
      chk("src switched at frame start", src_act, 0);

      // stop: enable held through the frame, dropped at frame end
      start = 0; tick();
      chk("state STOP", st, 3);
      repeat (10) tick();
      chk("gen_en held in STOP", gen_en, 1);
      vs = 1; tick();
      chk("gen_en off after frame end", gen_en, 0);
      chk("state IDLE after stop", st, 0);

      // ARM timeout with VSYNC stuck in blanking
      start = 1; tick();
      cnt = 0;
      while (st == 2'd1 && cnt < 200) begin tick(); cnt++; end
      chk("arm timeout clocks", cnt, ARM_TO);
      chk("err on timeout", err, 1);
      start = 0; tick();
      pulse_clr();
      chk("err cleared", err, 0);

      // asynchronous reset in the middle of a live frame
      start = 1; sel = 1;
      vs = 1; repeat (5) tick();
      vs = 0; repeat (6) tick();
      dreq = 1; repeat (10) tick();
      rst = 1; #1;
      chk("rst gen_en", gen_en, 0);
      chk("rst state", st, 0);
      chk("rst Y", y, 64);
      chk("rst C", c, 512);
      chk("rst fifo_rd", rd, 0);
      chk("rst src", src_act, 0);
      model_reset();
      tick();
      rst = 0; dreq = 0;
      tick();

      // randomized frames against the model
      chaos = 1; start = 1;
      for (int f = 0; f < 12; f++)
         do_frame($urandom_range(3, 1), $urandom_range(200, 30), $urandom_range(30, 3),
                  -1, 0, 0, ($urandom_range(1) == 1) ? 8 : 0);
      chaos = 0; clr = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
